uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver that deserializes the asynchronous `rx` line into parallel words. It consumes the oversampling enable `rx_clk_en` from the UART clock generator and runs a start/data/parity/stop state machine. Each received word goes to the host side over a valid/ready handshake, with per-word parity and framing status and an overrun indication. It sits directly downstream of the clock generator's receive-enable output.

## Interface
- `DATA_BITS`, 8, data bits per frame (5..9), LSB first on the line.
- `OVERSAMPLE`, 16, `rx_clk_en` ticks per bit period; must match the clock generator's receive ratio; even, ≥ 4.
- `clk`  input  1  system clock.
- `arst_n`  input  1  asynchronous active-low reset.
- `rx_clk_en`  input  1  oversampling tick, single-cycle pulse.
- `rx`  input  1  serial line, asynchronous, idle high.
- `parity_en`  input  1  1 = frame carries a parity bit.
- `parity_odd`  input  1  1 = odd parity, 0 = even.
- `rx_ready`  input  1  consumer accepts `rx_data`.
- `rx_data`  output  DATA_BITS  received word.
- `rx_valid`  output  1  `rx_data` and its status are valid.
- `parity_err`  output  1  parity mismatch on the held word; qualified by `rx_valid`.
- `frame_err`  output  1  stop bit sampled low on the held word; qualified by `rx_valid`.
- `overrun`  output  1  one-cycle pulse: a completed frame was dropped.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rx_s`.
- Tick counter is `$clog2(OVERSAMPLE)` bits wide. Bit index is `$clog2(DATA_BITS+1)` bits wide. Both advance only on `rx_clk_en`.
- States and transitions:
  - IDLE: on a tick with `rx_s`=0, clear the tick counter and go to START.
  - START: on a tick with counter = OVERSAMPLE/2−1 (mid-bit):
    - `rx_s`=1: false start; return to IDLE with no output.
    - `rx_s`=0: latch `parity_en`/`parity_odd`, clear the counter and bit index, go to DATA.
  - DATA: on a tick with counter = OVERSAMPLE−1, shift `rx_s` in LSB-first, clear the counter, increment the index. After DATA_BITS samples, go to PARITY if the latched `parity_en` is set, else STOP.
  - PARITY: sample at counter = OVERSAMPLE−1. Error if (XOR of data ^ sampled bit) ≠ latched `parity_odd`.
  - STOP: sample at counter = OVERSAMPLE−1. `frame_err` = !`rx_s`. Deliver the frame, then go to IDLE. Returning at mid-stop lets the next start edge be detected without loss.
- Delivery: if `rx_valid`=0, or `rx_valid`&&`rx_ready` in the same cycle, load `rx_data`, `parity_err` and `frame_err`, and set `rx_valid`. Otherwise drop the new frame, keep the held word and status, and pulse `overrun`.
- Frames with errors are still delivered; the status flags describe them.
- `rx_valid` clears on the cycle after `rx_valid`&&`rx_ready` unless a new frame is delivered in that same cycle.
- `parity_en`/`parity_odd` changes after start confirmation affect only the next frame.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0, state IDLE, counters 0, synchronizer 1.
- Line-to-state latency is 2 clk cycles (synchronizer), plus up to 1 tick period for edge detection.
- `rx_valid` and `overrun` assert on the clk edge that follows the `rx_clk_en` cycle of the stop-bit sample.
- `busy` rises on the edge leaving IDLE and falls on the edge returning to IDLE.
- Reset asserted mid-frame aborts immediately: partial data is discarded and no valid or overrun is produced.
- `rx_ready` without `rx_valid` has no effect. `rx_data` is stable while `rx_valid`=1 and not accepted.

## Test plan
- 8N1, OVERSAMPLE=16, send 0x55 with `rx_ready`=1 → one `rx_valid` pulse, `rx_data`=0x55, `parity_err`=`frame_err`=0.
- `rx` low for 4 ticks then high (glitch) → returns to IDLE, `busy` drops, no `rx_valid`. Then send 0x3C → `rx_data`=0x3C.
- 8E1, send 0xA3 with correct parity bit 0 → `parity_err`=0. Resend with parity bit 1 → `parity_err`=1, `rx_data`=0xA3.
- 8N1, send 0xFF with stop bit driven 0 → `rx_valid`=1, `rx_data`=0xFF, `frame_err`=1.
- `rx_ready`=0, send 0x11 then 0x22 back-to-back → `rx_data` holds 0x11 and `overrun` pulses once. Raise `rx_ready` → `rx_valid` clears the next cycle.
- Assert `arst_n` low mid-data of 0x5A, release, send 0x81 → no output for 0x5A, `rx_data`=0x81, all flags 0.

Source files
------------

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// Purpose: UART receiver. Oversampled start/data/parity/stop FSM delivering words on valid/ready.
// Latency: 2 clk synchronizer + up to 1 tick to detect the start edge; word valid on the edge after the mid-stop-bit tick.
// Backpressure: one held word; a frame completing while the held word is unaccepted is dropped and overrun pulses.
//
// Ports:
//   clk, arst_n            system clock, asynchronous active-low reset
//   rx_clk_en              oversampling tick (OVERSAMPLE per bit period)
//   rx                     asynchronous serial line, idle high
//   parity_en, parity_odd  frame format, latched at start-bit confirmation
//   rx_data/rx_valid/rx_ready  received word handshake
//   parity_err, frame_err  status of the held word, qualified by rx_valid
//   overrun                one-cycle pulse when a completed frame is dropped
//   busy                   receiver not idle
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 rx_clk_en,
   input  logic                 rx,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [IW-1:0]        idx, idx_nxt;
   logic                 rx_meta, rx_s;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_en_l, par_odd_l, par_err_r;
   logic                 shift_en, latch_cfg, par_chk, deliver;
   logic                 accept;

   assign busy   = (state != IDLE);
   assign accept = rx_valid && rx_ready;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   // The start bit is confirmed at its middle and the counter restarts there, so every
   // later sample (count wraps at OVERSAMPLE-1) lands mid-bit. Leaving STOP at mid-stop
   // leaves half a bit to catch the next start edge.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shift_en  = 1'b0;
      latch_cfg = 1'b0;
      par_chk   = 1'b0;
      deliver   = 1'b0;
      if (rx_clk_en) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  cnt_nxt   = '0;
                  state_nxt = START;
               end
            end
            START: begin
               if (cnt == CNT_MID) begin
                  if (rx_s) begin
                     state_nxt = IDLE;
                  end else begin
                     latch_cfg = 1'b1;
                     cnt_nxt   = '0;
                     idx_nxt   = '0;
                     state_nxt = DATA;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == CNT_END) begin
                  shift_en = 1'b1;
                  cnt_nxt  = '0;
                  idx_nxt  = idx + 1'b1;
                  if (idx == IDX_LAST) begin
                     state_nxt = par_en_l ? PARITY : STOP;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            PARITY: begin
               if (cnt == CNT_END) begin
                  par_chk   = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = STOP;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == CNT_END) begin
                  deliver   = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Frame assembly: format is frozen at start confirmation so mid-frame changes
   // only affect the following frame.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         shreg     <= '0;
         par_en_l  <= 1'b0;
         par_odd_l <= 1'b0;
         par_err_r <= 1'b0;
      end else begin
         if (latch_cfg) begin
            par_en_l  <= parity_en;
            par_odd_l <= parity_odd;
            par_err_r <= 1'b0;
         end
         if (shift_en) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         end
         if (par_chk) begin
            par_err_r <= ((^shreg) ^ rx_s) != par_odd_l;
         end
      end
   end

   // Single-entry output holding register; a new frame may replace a word that is
   // being accepted in the same cycle.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (deliver) begin
            if (!rx_valid || accept) begin
               rx_data    <= shreg;
               parity_err <= par_err_r;
               frame_err  <= !rx_s;
               rx_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (accept) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed bench for uart_rx: 8 data bits, OVERSAMPLE=16, one tick every 2 clk,
// so one bit period is 32 clk. Inputs change on the falling edge.
module tb_uart_rx;

   localparam int BIT_CLKS = 32;

   logic       clk = 1'b0;
   logic       arst_n;
   logic       rx_clk_en;
   logic       rx;
   logic       parity_en;
   logic       parity_odd;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   // Handshake / overrun observations, sampled 1 ns after the falling edge.
   int         acc_cnt = 0;
   int         ovr_cnt = 0;
   logic [7:0] last_data = '0;
   logic       last_perr = 1'b0;
   logic       last_ferr = 1'b0;

   int acc0, ovr0;

   uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .rx_clk_en  (rx_clk_en),
      .rx         (rx),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .rx_ready   (rx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   initial forever #5 clk = ~clk;

   // Tick every other clock.
   initial begin
      rx_clk_en = 1'b0;
      forever begin
         @(negedge clk);
         rx_clk_en = ~rx_clk_en;
      end
   end

   always @(negedge clk) begin
      #1;
      if (rx_valid && rx_ready) begin
         acc_cnt   = acc_cnt + 1;
         last_data = rx_data;
         last_perr = parity_err;
         last_ferr = frame_err;
      end
      if (overrun) ovr_cnt = ovr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      idle(BIT_CLKS);
   endtask

   task automatic send(input logic [7:0] d, input logic with_par, input logic par_bit,
                       input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (with_par) drive_bit(par_bit);
      drive_bit(stop_bit);
      rx = 1'b1;
   endtask

   initial begin
      arst_n     = 1'b0;
      rx         = 1'b1;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      rx_ready   = 1'b1;
      idle(4);

      // Reset state
      check("rst_valid", rx_valid, 0);
      check("rst_data", rx_data, 8'h00);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_perr", parity_err, 0);
      check("rst_ferr", frame_err, 0);
      arst_n = 1'b1;
      idle(10);

      // 8N1 0x55
      send(8'h55, 1'b0, 1'b0, 1'b1);
      idle(20);
      check("n81_count", acc_cnt, 1);
      check("n81_data", last_data, 8'h55);
      check("n81_perr", last_perr, 0);
      check("n81_ferr", last_ferr, 0);
      check("n81_busy_after", busy, 0);

      // Glitch: 4 ticks low, then high -> false start
      rx = 1'b0;
      idle(7);
      check("glitch_busy_hi", busy, 1);
      idle(1);
      rx = 1'b1;
      idle(40);
      check("glitch_busy_lo", busy, 0);
      check("glitch_no_valid", acc_cnt, 1);
      send(8'h3C, 1'b0, 1'b0, 1'b1);
      idle(20);
      check("after_glitch_count", acc_cnt, 2);
      check("after_glitch_data", last_data, 8'h3C);

      // 8E1: 0xA3 has four ones, correct even-parity bit is 0
      parity_en  = 1'b1;
      parity_odd = 1'b0;
      send(8'hA3, 1'b1, 1'b0, 1'b1);
      idle(20);
      check("e81_ok_count", acc_cnt, 3);
      check("e81_ok_data", last_data, 8'hA3);
      check("e81_ok_perr", last_perr, 0);
      send(8'hA3, 1'b1, 1'b1, 1'b1);
      idle(20);
      check("e81_bad_count", acc_cnt, 4);
      check("e81_bad_data", last_data, 8'hA3);
      check("e81_bad_perr", last_perr, 1);
      check("e81_bad_ferr", last_ferr, 0);

      // 8N1 0xFF with stop bit low
      parity_en = 1'b0;
      send(8'hFF, 1'b0, 1'b0, 1'b0);
      idle(60);
      check("ferr_count", acc_cnt, 5);
      check("ferr_data", last_data, 8'hFF);
      check("ferr_flag", last_ferr, 1);
      check("ferr_perr", last_perr, 0);
      check("ferr_busy", busy, 0);

      // Overrun: two back-to-back frames with no consumer
      rx_ready = 1'b0;
      acc0 = acc_cnt;
      ovr0 = ovr_cnt;
      send(8'h11, 1'b0, 1'b0, 1'b1);
      send(8'h22, 1'b0, 1'b0, 1'b1);
      idle(20);
      check("ovr_valid", rx_valid, 1);
      check("ovr_hold_data", rx_data, 8'h11);
      check("ovr_pulses", ovr_cnt - ovr0, 1);
      check("ovr_no_accept", acc_cnt - acc0, 0);
      rx_ready = 1'b1;
      #1;
      check("ovr_valid_before_edge", rx_valid, 1);
      idle(1);
      check("ovr_valid_cleared", rx_valid, 0);
      check("ovr_accept_once", acc_cnt - acc0, 1);
      check("ovr_accept_data", last_data, 8'h11);

      // Reset in the middle of 0x5A data bits
      acc0 = acc_cnt;
      ovr0 = ovr_cnt;
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      idle(5);
      check("midrst_busy_before", busy, 1);
      arst_n = 1'b0;
      rx     = 1'b1;
      #1;
      check("midrst_busy_now", busy, 0);
      idle(3);
      arst_n = 1'b1;
      idle(40);
      check("midrst_no_valid", acc_cnt - acc0, 0);
      check("midrst_no_ovr", ovr_cnt - ovr0, 0);
      send(8'h81, 1'b0, 1'b0, 1'b1);
      idle(20);
      check("post_rst_count", acc_cnt - acc0, 1);
      check("post_rst_data", last_data, 8'h81);
      check("post_rst_perr", last_perr, 0);
      check("post_rst_ferr", last_ferr, 0);
      check("post_rst_ovr", ovr_cnt - ovr0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
